// File: rtl/alu_74181_serial.sv
// rtl/alu_74181_serial.sv - slice-serial 74181-style ALU behind a start/busy/done handshake
module alu_74181_serial #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             p_out,
   output logic             g_out,
   output logic             eq
);
   localparam int N  = WIDTH / SLICE_W;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]         state;
   logic [KW-1:0]      k;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   f_r;
   logic [3:0]         s_r;
   logic               m_r;
   logic               carry_r;
   logic               p_r;
   logic               g_r;

   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] u_sl;
   logic [SLICE_W-1:0] v_sl;
   logic [SLICE_W-1:0] f_sl;
   logic [SLICE_W:0]   gen_sum;
   logic [SLICE_W:0]   sum_sl;
   logic               p_sl;
   logic               g_sl;
   logic               p_next;
   logic               g_next;
   logic [WIDTH-1:0]   f_next;
   logic               accept;
   logic               last;

   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_DONE);
   assign accept = start && (state != ST_RUN);
   assign last   = (state == ST_RUN) && (k == KW'(N - 1));

   // Slice generate is the carry of u+v with no carry in, so G/P stay independent of cin.
   always_comb begin
      a_sl    = a_r[int'(k)*SLICE_W +: SLICE_W];
      b_sl    = b_r[int'(k)*SLICE_W +: SLICE_W];
      u_sl    = a_sl | (b_sl & {SLICE_W{s_r[0]}}) | (~b_sl & {SLICE_W{s_r[1]}});
      v_sl    = (a_sl & ~b_sl & {SLICE_W{s_r[2]}}) | (a_sl & b_sl & {SLICE_W{s_r[3]}});
      gen_sum = {1'b0, u_sl} + {1'b0, v_sl};
      sum_sl  = gen_sum + {{SLICE_W{1'b0}}, carry_r};
      g_sl    = gen_sum[SLICE_W];
      p_sl    = &(u_sl ^ v_sl);
      p_next  = p_sl & p_r;
      g_next  = g_sl | (p_sl & g_r);
      f_sl    = m_r ? ~(u_sl ^ v_sl) : sum_sl[SLICE_W-1:0];
      f_next  = f_r;
      f_next[int'(k)*SLICE_W +: SLICE_W] = f_sl;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         k       <= '0;
         a_r     <= '0;
         b_r     <= '0;
         f_r     <= '0;
         s_r     <= '0;
         m_r     <= 1'b0;
         carry_r <= 1'b0;
         p_r     <= 1'b0;
         g_r     <= 1'b0;
         f       <= '0;
         cout    <= 1'b0;
         p_out   <= 1'b0;
         g_out   <= 1'b0;
         eq      <= 1'b0;
      end else if (accept) begin
         state   <= ST_RUN;
         k       <= '0;
         a_r     <= a;
         b_r     <= b;
         s_r     <= s;
         m_r     <= m;
         carry_r <= cin;
         p_r     <= 1'b1;
         g_r     <= 1'b0;
      end else if (state == ST_RUN) begin
         f_r     <= f_next;
         carry_r <= sum_sl[SLICE_W];
         p_r     <= p_next;
         g_r     <= g_next;
         k       <= k + 1'b1;
         if (last) begin
            state <= ST_DONE;
            k     <= '0;
            f     <= f_next;
            cout  <= ~m_r & sum_sl[SLICE_W];
            p_out <= p_next;
            g_out <= g_next;
            eq    <= &f_next;
         end
      end else begin
         state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_alu_74181_serial.sv
// tb/tb_alu_74181_serial.sv - randomized and directed bench for alu_74181_serial
module tb_alu_74181_serial;
   localparam int WIDTH   = 16;
   localparam int SLICE_W = 4;
   localparam int N       = WIDTH / SLICE_W;

   typedef struct packed {
      logic [WIDTH-1:0] f;
      logic             cout;
      logic             p;
      logic             g;
      logic             eq;
   } res_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [3:0]       s = '0;
   logic             m = 1'b0;
   logic             cin = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] f;
   logic             cout;
   logic             p_out;
   logic             g_out;
   logic             eq;

   int checks = 0;
   int failures = 0;

   int   rem = 0;
   bit   m_done = 1'b0;
   res_t exp_r = '0;
   res_t pend = '0;

   alu_74181_serial #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
      .busy(busy), .done(done), .f(f), .cout(cout), .p_out(p_out), .g_out(g_out), .eq(eq)
   );

   always #5 clk = ~clk;

   function automatic res_t ref_alu(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                    input logic [3:0] si, input logic mi, input logic ci);
      res_t             r;
      logic [WIDTH-1:0] u;
      logic [WIDTH-1:0] v;
      logic [WIDTH:0]   full;
      u = ai | (bi & {WIDTH{si[0]}}) | (~bi & {WIDTH{si[1]}});
      v = (ai & ~bi & {WIDTH{si[2]}}) | (ai & bi & {WIDTH{si[3]}});
      r.p = &(u ^ v);
      full = {1'b0, u} + {1'b0, v};
      r.g = full[WIDTH];
      if (mi) begin
         case (si)
            4'h0: r.f = ~ai;
            4'h1: r.f = ~(ai | bi);
            4'h2: r.f = ~ai & bi;
            4'h3: r.f = '0;
            4'h4: r.f = ~(ai & bi);
            4'h5: r.f = ~bi;
            4'h6: r.f = ai ^ bi;
            4'h7: r.f = ai & ~bi;
            4'h8: r.f = ~ai | bi;
            4'h9: r.f = ~(ai ^ bi);
            4'hA: r.f = bi;
            4'hB: r.f = ai & bi;
            4'hC: r.f = '1;
            4'hD: r.f = ai | ~bi;
            4'hE: r.f = ai | bi;
            default: r.f = ai;
         endcase
         r.cout = 1'b0;
      end else begin
         full = {1'b0, u} + {1'b0, v} + {{WIDTH{1'b0}}, ci};
         r.f = full[WIDTH-1:0];
         r.cout = full[WIDTH];
      end
      r.eq = &r.f;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Transaction-level model: a countdown of remaining RUN cycles and the pending result.
   always @(posedge clk) begin
      if (rst) begin
         rem = 0;
         m_done = 1'b0;
         exp_r = '0;
      end else if (rem > 0) begin
         rem = rem - 1;
         m_done = (rem == 0);
         if (rem == 0) exp_r = pend;
      end else begin
         m_done = 1'b0;
         if (start) begin
            pend = ref_alu(a, b, s, m, cin);
            rem = N;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("busy", busy, rem > 0);
      chk("done", done, m_done);
      chk("busy_done_excl", busy & done, 0);
      chk("f", f, exp_r.f);
      chk("cout", cout, exp_r.cout);
      chk("p_out", p_out, exp_r.p);
      chk("g_out", g_out, exp_r.g);
      chk("eq", eq, exp_r.eq);
   end

   task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input logic [3:0] si, input logic mi, input logic ci);
      @(negedge clk);
      a = ai; b = bi; s = si; m = mi; cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 20);
      chk("done_timeout", done, 1);
   endtask

   initial begin
      int   n;
      res_t r;

      r = ref_alu(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0);
      chk("model_add", r.f, 16'h2201);
      r = ref_alu(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
      chk("model_xor", r.f, 16'h0FF0);

      repeat (3) @(negedge clk);
      rst = 1'b0;

      issue(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0);
      wait_done(n);
      chk("add_latency", n, 4);
      chk("add_f", f, 16'h2201);
      chk("add_cout", cout, 0);
      chk("add_eq", eq, 0);

      issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
      wait_done(n);
      chk("ripple_f", f, 16'h0000);
      chk("ripple_cout", cout, 1);
      chk("ripple_g", g_out, 1);
      chk("ripple_p", p_out, 0);

      issue(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b0);
      wait_done(n);
      chk("sub0_f", f, 16'hFFFF);
      chk("sub0_eq", eq, 1);
      chk("sub0_cout", cout, 0);
      chk("sub0_p", p_out, 1);
      chk("sub0_g", g_out, 0);

      issue(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1);
      wait_done(n);
      chk("sub1_f", f, 16'h0000);
      chk("sub1_cout", cout, 1);
      chk("sub1_eq", eq, 0);

      issue(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
      wait_done(n);
      chk("xor_f", f, 16'h0FF0);
      chk("xor_cout", cout, 0);

      issue(16'h1357, 16'h2468, 4'b1100, 1'b1, 1'b0);
      wait_done(n);
      chk("ones_f", f, 16'hFFFF);
      chk("ones_eq", eq, 1);

      // Stray start two cycles into RUN must be ignored.
      issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      chk("ignored_start_f", f, 16'h3333);

      // Start in the DONE cycle is accepted.
      issue(16'h0100, 16'h0023, 4'b1001, 1'b0, 1'b1);
      wait_done(n);
      chk("b2b_first_f", f, 16'h0124);
      issue(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0);
      wait_done(n);
      chk("b2b_latency", n, 4);
      chk("b2b_second_f", f, 16'h0000);
      chk("b2b_second_cout", cout, 1);

      issue(16'h00FF, 16'h0F0F, 4'b1110, 1'b1, 1'b0);
      wait_done(n);
      chk("or_f", f, 16'h0FFF);

      // Reset during RUN aborts with no done pulse.
      issue(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_f", f, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", done, 0);
      end

      issue(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0);
      wait_done(n);
      chk("post_reset_latency", n, 4);
      chk("post_reset_f", f, 16'h2201);

      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(WIDTH'($urandom), WIDTH'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         wait_done(n);
         chk("rand_latency", n, N);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
